// File: rtl/uart_tx.sv
// UART transmit serializer: pops bytes from the TX FIFO and shifts them out as
// start / data (LSB first) / optional parity / 1-2 stop bits at a runtime divisor.
module uart_tx #(
  parameter int unsigned DataBits = 8,
  parameter int unsigned DivWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                tx_en_i,
  input  logic [DivWidth-1:0] baud_div_i,
  input  logic                parity_en_i,
  input  logic                parity_odd_i,
  input  logic                stop2_i,
  input  logic                fifo_empty_i,
  input  logic [DataBits-1:0] fifo_rdata_i,
  output logic                fifo_rd_en_o,
  output logic                tx_o,
  output logic                busy_o,
  output logic                tx_done_o
);

  localparam int unsigned BitCntW = (DataBits > 1) ? $clog2(DataBits) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e                state_q;
  logic [DataBits-1:0]   shift_q;
  logic [DivWidth-1:0]   div_q;
  logic [DivWidth-1:0]   baud_cnt_q;
  logic [BitCntW-1:0]    bit_cnt_q;
  logic                  par_en_q;
  logic                  par_bit_q;
  logic                  stop2_q;
  logic                  stop_cnt_q;
  logic                  tx_q;
  logic                  busy_q;
  logic                  done_q;

  logic                  pop_c;
  logic                  bit_end_c;
  logic                  last_data_c;
  logic [DivWidth-1:0]   div_in_c;

  // A divisor of zero behaves exactly like one.
  assign div_in_c    = (baud_div_i == '0) ? DivWidth'(1) : baud_div_i;
  assign bit_end_c   = (baud_cnt_q == div_q - DivWidth'(1));
  assign last_data_c = (bit_cnt_q == BitCntW'(DataBits - 1));

  // Pop is held low while in reset even if the FIFO is non-empty.
  assign pop_c        = rst_ni && (state_q == StIdle) && tx_en_i && !fifo_empty_i;
  assign fifo_rd_en_o = pop_c;

  assign tx_o      = tx_q;
  assign busy_o    = busy_q;
  assign tx_done_o = done_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      div_q      <= DivWidth'(1);
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          tx_q       <= 1'b1;
          busy_q     <= 1'b0;
          baud_cnt_q <= '0;
          if (pop_c) begin
            state_q <= StLoad;
            busy_q  <= 1'b1;
          end
        end

        // Read data arrives this cycle; configuration is frozen for the frame.
        StLoad: begin
          shift_q    <= fifo_rdata_i;
          div_q      <= div_in_c;
          par_en_q   <= parity_en_i;
          par_bit_q  <= (^fifo_rdata_i) ^ parity_odd_i;
          stop2_q    <= stop2_i;
          baud_cnt_q <= '0;
          bit_cnt_q  <= '0;
          stop_cnt_q <= 1'b0;
          tx_q       <= 1'b0;
          busy_q     <= 1'b1;
          state_q    <= StStart;
        end

        StStart: begin
          if (bit_end_c) begin
            baud_cnt_q <= '0;
            tx_q       <= shift_q[0];
            state_q    <= StData;
          end else begin
            baud_cnt_q <= baud_cnt_q + DivWidth'(1);
          end
        end

        StData: begin
          if (bit_end_c) begin
            baud_cnt_q <= '0;
            shift_q    <= shift_q >> 1;
            bit_cnt_q  <= bit_cnt_q + BitCntW'(1);
            if (last_data_c) begin
              if (par_en_q) begin
                tx_q    <= par_bit_q;
                state_q <= StParity;
              end else begin
                tx_q    <= 1'b1;
                state_q <= StStop;
              end
            end else begin
              tx_q <= shift_q[1];
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + DivWidth'(1);
          end
        end

        StParity: begin
          if (bit_end_c) begin
            baud_cnt_q <= '0;
            tx_q       <= 1'b1;
            state_q    <= StStop;
          end else begin
            baud_cnt_q <= baud_cnt_q + DivWidth'(1);
          end
        end

        // Second stop bit reuses the baud counter for another full bit period.
        StStop: begin
          tx_q <= 1'b1;
          if (bit_end_c) begin
            baud_cnt_q <= '0;
            if (stop2_q && !stop_cnt_q) begin
              stop_cnt_q <= 1'b1;
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + DivWidth'(1);
          end
        end

        default: begin
          state_q <= StIdle;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed + randomized bench for uart_tx; expected line waveforms are built
// from the frame rules (bit list x divisor) and compared cycle by cycle.
module tb_uart_tx;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        tx_en_i;
  logic [15:0] baud_div_i;
  logic        parity_en_i;
  logic        parity_odd_i;
  logic        stop2_i;
  logic        fifo_empty_i;
  logic [7:0]  fifo_rdata_i = 8'h00;
  logic        fifo_rd_en_o;
  logic        tx_o;
  logic        busy_o;
  logic        tx_done_o;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem [256];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pops   = 0;

  uart_tx #(.DataBits(8), .DivWidth(16)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .tx_en_i      (tx_en_i),
    .baud_div_i   (baud_div_i),
    .parity_en_i  (parity_en_i),
    .parity_odd_i (parity_odd_i),
    .stop2_i      (stop2_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_rdata_i (fifo_rdata_i),
    .fifo_rd_en_o (fifo_rd_en_o),
    .tx_o         (tx_o),
    .busy_o       (busy_o),
    .tx_done_o    (tx_done_o)
  );

  always #5 clk_i = ~clk_i;

  // FIFO model: read data appears the cycle after a pop.
  assign fifo_empty_i = (wr_ptr == rd_ptr);
  always @(posedge clk_i) begin
    if (fifo_rd_en_o) begin
      fifo_rdata_i <= mem[rd_ptr % 256];
      rd_ptr       <= rd_ptr + 1;
      pops         <= pops + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    mem[wr_ptr % 256] = d;
    wr_ptr++;
  endtask

  task automatic set_cfg(input int div, input bit pe, input bit po, input bit s2);
    baud_div_i   = 16'(div);
    parity_en_i  = pe;
    parity_odd_i = po;
    stop2_i      = s2;
  endtask

  // Waits for a start bit, then compares every cycle of the frame to the
  // expected bit sequence; gap returns idle-high cycles before the start bit.
  task automatic check_frame(input logic [7:0] data, input int div, input bit pe,
                             input bit po, input bit s2, input bit mid_change,
                             output int gap);
    logic exp_bits [12];
    int nb;
    int n;
    int bad;
    exp_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[1 + i] = data[i];
    nb = 9;
    if (pe) begin
      exp_bits[nb] = (^data) ^ po;
      nb++;
    end
    exp_bits[nb] = 1'b1;
    nb++;
    if (s2) begin
      exp_bits[nb] = 1'b1;
      nb++;
    end
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (tx_o !== 1'b0 && n < 300);
    gap = n;
    chk("start_seen", 32'(tx_o), 32'd0);
    bad = 0;
    for (int i = 0; i < nb * div; i++) begin
      if (i > 0) @(negedge clk_i);
      if (mid_change && i == 3 * div) begin
        tx_en_i    = 1'b0;
        baud_div_i = 16'd8;
      end
      if (tx_o !== exp_bits[i / div]) bad++;
      if (busy_o !== 1'b1) bad++;
      if (tx_done_o !== 1'b0) bad++;
    end
    chk("frame_bits", 32'(bad), 32'd0);
    @(negedge clk_i);
    chk("done_pulse", 32'(tx_done_o), 32'd1);
    chk("busy_fall", 32'(busy_o), 32'd0);
    chk("idle_high", 32'(tx_o), 32'd1);
  endtask

  initial begin
    int gap;
    int p0;
    int n;
    logic [7:0] d;
    int div;
    bit pe, po, s2;

    rst_ni  = 1'b0;
    tx_en_i = 1'b0;
    set_cfg(4, 0, 0, 0);
    repeat (3) @(negedge clk_i);
    chk("rst_tx", 32'(tx_o), 32'd1);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(tx_done_o), 32'd0);
    push(8'hA5);
    tx_en_i = 1'b1;
    #1;
    chk("rst_rd_en", 32'(fifo_rd_en_o), 32'd0);

    // Basic 8N1 frame at div 4
    @(negedge clk_i);
    p0 = pops;
    rst_ni = 1'b1;
    check_frame(8'hA5, 4, 0, 0, 0, 0, gap);
    chk("basic_gap", 32'(gap), 32'd2);
    chk("basic_pops", 32'(pops - p0), 32'd1);

    // Even parity, then odd parity with two stop bits
    set_cfg(4, 1, 0, 0);
    push(8'hA5);
    check_frame(8'hA5, 4, 1, 0, 0, 0, gap);
    set_cfg(4, 1, 1, 1);
    push(8'hA5);
    check_frame(8'hA5, 4, 1, 1, 1, 0, gap);

    // Back-to-back drain at div 1
    repeat (3) @(negedge clk_i);
    tx_en_i = 1'b0;
    set_cfg(1, 0, 0, 0);
    push(8'h00);
    push(8'hFF);
    push(8'h3C);
    p0 = pops;
    tx_en_i = 1'b1;
    check_frame(8'h00, 1, 0, 0, 0, 0, gap);
    check_frame(8'hFF, 1, 0, 0, 0, 0, gap);
    chk("b2b_gap1", 32'(gap), 32'd2);
    check_frame(8'h3C, 1, 0, 0, 0, 0, gap);
    chk("b2b_gap2", 32'(gap), 32'd2);
    repeat (10) @(negedge clk_i);
    chk("b2b_pops", 32'(pops - p0), 32'd3);
    chk("b2b_idle_busy", 32'(busy_o), 32'd0);

    // Divisor/enable change mid-frame; second byte must stay in the FIFO
    tx_en_i = 1'b0;
    set_cfg(4, 0, 0, 0);
    push(8'h5A);
    push(8'hC3);
    p0 = pops;
    tx_en_i = 1'b1;
    check_frame(8'h5A, 4, 0, 0, 0, 1, gap);
    repeat (30) @(negedge clk_i);
    chk("mid_pops", 32'(pops - p0), 32'd1);
    chk("mid_idle_busy", 32'(busy_o), 32'd0);
    chk("mid_idle_tx", 32'(tx_o), 32'd1);
    chk("mid_no_pop", 32'(fifo_rd_en_o), 32'd0);

    // Reset in the middle of the data bits
    set_cfg(4, 0, 0, 0);
    tx_en_i = 1'b1;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (tx_o !== 1'b0 && n < 300);
    repeat (12) @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    chk("async_rst_tx", 32'(tx_o), 32'd1);
    chk("async_rst_busy", 32'(busy_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    p0 = pops;
    repeat (5) @(negedge clk_i);
    chk("post_rst_busy", 32'(busy_o), 32'd0);
    chk("post_rst_pops", 32'(pops - p0), 32'd0);
    push(8'h96);
    check_frame(8'h96, 4, 0, 0, 0, 0, gap);
    chk("post_rst_gap", 32'(gap), 32'd2);

    // Divisor 0 and 1 both give single-cycle bits
    set_cfg(0, 0, 0, 0);
    push(8'h6B);
    check_frame(8'h6B, 1, 0, 0, 0, 0, gap);
    set_cfg(1, 0, 0, 0);
    push(8'h6B);
    check_frame(8'h6B, 1, 0, 0, 0, 0, gap);

    // Randomized frames
    for (int k = 0; k < 8; k++) begin
      d   = 8'($urandom_range(0, 255));
      div = int'($urandom_range(0, 5));
      pe  = 1'($urandom_range(0, 1));
      po  = 1'($urandom_range(0, 1));
      s2  = 1'($urandom_range(0, 1));
      set_cfg(div, pe, po, s2);
      p0 = pops;
      push(d);
      check_frame(d, (div == 0) ? 1 : div, pe, po, s2, 0, gap);
      chk("rand_pops", 32'(pops - p0), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmit serializer. Drains bytes from the TX FIFO and drives the serial line.
- Frame format: start bit, DataBits data bits LSB first, optional parity bit, then 1 or 2 stop bits.
- Sits between the TX FIFO read port and the tx pad.
- Bit timing comes from a runtime clock-divisor input, so one RTL instance serves any baud rate.

Parameters:
- DataBits, 8, data bits per frame (5..9).
- DivWidth, 16, width of the baud_div_i divisor.

Ports:
- clk_i  input  1  system clock
- rst_ni  input  1  asynchronous active-low reset
- tx_en_i  input  1  permit starting new frames
- baud_div_i  input  DivWidth  clock cycles per serial bit; 0 and 1 both mean 1
- parity_en_i  input  1  append parity bit
- parity_odd_i  input  1  1 = odd parity, 0 = even
- stop2_i  input  1  1 = two stop bits, 0 = one
- fifo_empty_i  input  1  TX FIFO empty flag
- fifo_rdata_i  input  DataBits  TX FIFO read data; valid the cycle after a pop
- fifo_rd_en_o  output  1  TX FIFO pop strobe
- tx_o  output  1  serial line, idles high
- busy_o  output  1  frame in progress
- tx_done_o  output  1  one-cycle pulse at end of last stop bit

Behaviour:
- Async reset (rst_ni low):
  - state=IDLE; tx_o=1; busy_o=0; tx_done_o=0; counters and shift register cleared.
  - fifo_rd_en_o=0 during reset.
  - Reset mid-frame aborts the frame immediately; tx_o goes high asynchronously; the popped byte is lost.
- Outputs: tx_o, busy_o and tx_done_o are registered. fifo_rd_en_o is combinational: IDLE && tx_en_i && !fifo_empty_i.
- FSM states:
  - IDLE: tx_o=1. If the pop condition holds, pop and go to LOAD.
  - LOAD (1 cycle):
    - Capture fifo_rdata_i into the shift register.
    - Latch baud_div_i, parity_en_i, parity_odd_i, stop2_i. Config changes mid-frame have no effect.
    - Compute parity: XOR of data bits, inverted when parity_odd_i=1.
    - Clear the baud counter. Go to START.
  - START: tx_o=0 for div cycles, then go to DATA.
  - DATA:
    - tx_o = shift[0] for div cycles per bit.
    - Shift right and increment the bit counter at each bit boundary.
    - After DataBits bits, go to PARITY if enabled, else STOP.
  - PARITY: tx_o = parity bit for div cycles, then go to STOP.
  - STOP:
    - tx_o=1 for div cycles (one stop bit) or 2*div cycles (two).
    - On the final stop-bit cycle, tx_done_o pulses the next cycle and the state returns to IDLE.
- Baud counter: counts 0..div-1; the bit advances when count==div-1. div = max(baud_div_i, 1).
- busy_o=1 in LOAD, START, DATA, PARITY and STOP.
- Frame length in cycles: div*(1 + DataBits + parity_en + 1 + stop2).
- Back-to-back frames: exactly 2 idle-high cycles (IDLE + LOAD) between the last stop-bit cycle and the next start bit.
- Pop rules:
  - Never pops when fifo_empty_i=1 or outside IDLE.
  - Exactly one pop per frame.
- tx_en_i deasserted mid-frame: the current frame completes; no new pop.
- tx_en_i=0 with a non-empty FIFO: stays in IDLE, no pop.

Test Plan:
- Reset values: hold rst_ni=0 -> tx_o=1, busy_o=0, fifo_rd_en_o=0, tx_done_o=0.
- Basic frame: baud_div=4, no parity, 1 stop; FIFO holds 0xA5; tx_en=1.
  - One pop cycle.
  - Line after LOAD: 0 | 1,0,1,0,0,1,0,1 | 1, each bit 4 cycles, 40 cycles total.
  - tx_done_o pulses once; busy_o then falls.
- Parity and stop bits: 0xA5, parity_en=1.
  - Even parity -> parity bit 0; odd -> 1.
  - stop2=1 gives a 12-bit frame = 48 cycles at div=4.
- Back-to-back and drain: FIFO holds 0x00, 0xFF, 0x3C at div=1.
  - Three frames, each separated by exactly 2 idle-high cycles.
  - Exactly 3 pops; no pop once fifo_empty_i=1.
- Mid-frame events:
  - Change baud_div 4->8 and deassert tx_en during DATA -> frame finishes at div=4; no further pop.
  - Assert rst_ni=0 mid-DATA -> tx_o=1 immediately and state IDLE after release.
- Divisor edge cases: baud_div=0 and baud_div=1 -> identical 10-cycle frames.
